// File: rtl/centroid_ctrl.sv
// Per-frame mask centroid: accumulates zeroth/first moments over a frame and, at the
// next frame start, divides them with one shared restoring divider (x first, then y).
module centroid_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_in,
  input  logic        v_sync_in,
  input  logic        mask_in,
  output logic [10:0] x_out,
  output logic [10:0] y_out,
  output logic        valid_out,
  output logic        busy
);

  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);

  // Coordinates are 11 bits wide, so larger images cannot be represented.
  if (IMG_W < 2 || IMG_W > 2048 || IMG_H < 1 || IMG_H > 2048) begin : g_size_check
    $error("centroid_ctrl: image size out of range");
  end

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, UPDATE} state_t;

  state_t      state;
  logic        prev_vs;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic [31:0] m00;
  logic [31:0] m10;
  logic [31:0] m01;
  logic [31:0] den;
  logic [31:0] num_y;
  logic [31:0] rem;
  logic [31:0] q;
  logic [10:0] qx;
  logic [4:0]  iter;
  logic        fs;

  logic [32:0] trial;
  logic [31:0] rem_next;
  logic [31:0] q_next;

  assign fs = v_sync_in & ~prev_vs;

  // One restoring step: shift the next numerator bit (held in q's MSB) into the remainder.
  always_comb begin
    trial    = {rem, q[31]};
    rem_next = trial[31:0];
    q_next   = {q[30:0], 1'b0};
    if (trial >= {1'b0, den}) begin
      rem_next = 32'(trial - {1'b0, den});
      q_next   = {q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vs <= 1'b0;
      x_pos   <= '0;
      y_pos   <= '0;
      m00     <= '0;
      m10     <= '0;
      m01     <= '0;
    end else begin
      prev_vs <= v_sync_in;
      if (v_sync_in) begin
        x_pos <= '0;
        y_pos <= '0;
      end else if (de_in) begin
        if (x_pos == X_LAST) begin
          x_pos <= '0;
          y_pos <= y_pos + 11'd1;
        end else begin
          x_pos <= x_pos + 11'd1;
        end
      end
      if (fs) begin
        m00 <= '0;
        m10 <= '0;
        m01 <= '0;
      end else if (de_in && mask_in) begin
        m00 <= m00 + 32'd1;
        m10 <= m10 + {21'd0, x_pos};
        m01 <= m01 + {21'd0, y_pos};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      den       <= '0;
      num_y     <= '0;
      rem       <= '0;
      q         <= '0;
      qx        <= '0;
      iter      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fs) begin
            den   <= m00;
            q     <= m10;
            num_y <= m01;
            rem   <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= DIV_X;
          end
        end
        DIV_X: begin
          q    <= q_next;
          rem  <= rem_next;
          iter <= iter + 5'd1;
          if (iter == 5'd31) begin
            qx    <= q_next[10:0];
            q     <= num_y;
            rem   <= '0;
            state <= DIV_Y;
          end
        end
        DIV_Y: begin
          q    <= q_next;
          rem  <= rem_next;
          iter <= iter + 5'd1;
          if (iter == 5'd31) state <= UPDATE;
        end
        UPDATE: begin
          // An empty frame keeps the last good centroid but flags it as stale.
          if (den != 32'd0) begin
            x_out     <= qx;
            y_out     <= q[10:0];
            valid_out <= 1'b1;
          end else begin
            valid_out <= 1'b0;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
